// File: rtl/bin_to_ascii_digits_if.sv
// Handshake and data bundle between the timer register block and the digit converter.
interface bin_to_ascii_digits_if #(
    parameter int BIN_WIDTH = 20,
    parameter int DIGITS    = 6
);
    logic                   start;
    logic [BIN_WIDTH-1:0]   bin_in;
    logic                   busy;
    logic                   done;
    logic [8*DIGITS-1:0]    chars;
    logic                   overflow;

    modport master (
        output start, bin_in,
        input  busy, done, chars, overflow
    );

    modport slave (
        input  start, bin_in,
        output busy, done, chars, overflow
    );
endinterface

// File: rtl/bin_to_ascii_digits.sv
// Binary to row of ASCII decimal digits via serial double-dabble, one bit per clock.
// Latency: start edge -> done 2+BIN_WIDTH cycles later; a start during busy or the done cycle is dropped.
module bin_to_ascii_digits #(
    parameter int BIN_WIDTH = 20,
    parameter int DIGITS    = 6,
    parameter bit LZ_BLANK  = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    bin_to_ascii_digits_if.slave   bus
);

    localparam int CW = $clog2(BIN_WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    function automatic logic [63:0] f_pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    function automatic logic [8*DIGITS-1:0] f_idle_chars();
        logic [8*DIGITS-1:0] c;
        c = '0;
        for (int k = 0; k < DIGITS; k++) begin
            c[8*k +: 8] = (k == 0 || !LZ_BLANK) ? 8'h30 : 8'h20;
        end
        return c;
    endfunction

    localparam logic [63:0]   LP_LIMIT    = f_pow10(DIGITS);
    localparam logic [CW-1:0] LP_CNT_LAST = CW'(BIN_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [BIN_WIDTH-1:0]   r_bin;
    logic [BW-1:0]          r_bcd;
    logic [CW-1:0]          r_cnt;
    logic                   r_ovf_pend;
    logic [8*DIGITS-1:0]    r_chars;
    logic                   r_ovf;
    logic                   r_done;

    logic                   w_accept;
    logic [63:0]            w_bin_ext;
    logic [BW-1:0]          w_bcd_adj;
    logic [8*DIGITS-1:0]    w_chars;
    logic                   w_lead;
    logic [3:0]             w_nib;

    // The done cycle itself also refuses a start, so back-to-back requests land one cycle after done.
    assign w_accept  = (r_state == ST_IDLE) && bus.start && !r_done;
    assign w_bin_ext = 64'(bus.bin_in);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_accept) w_state_nxt = ST_SHIFT;
            ST_SHIFT:  if (r_cnt == LP_CNT_LAST) w_state_nxt = ST_FINISH;
            ST_FINISH: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) begin
                w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
            end
        end
    end

    // Walk from the most significant digit; w_lead stays set until the first nonzero digit.
    always_comb begin
        w_chars = '0;
        w_lead  = 1'b1;
        w_nib   = 4'd0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_nib = r_bcd[4*k +: 4];
            if (r_ovf_pend) begin
                w_chars[8*k +: 8] = 8'h2D;
            end else if (LZ_BLANK && w_lead && (k != 0) && (w_nib == 4'd0)) begin
                w_chars[8*k +: 8] = 8'h20;
            end else begin
                w_chars[8*k +: 8] = 8'h30 + {4'd0, w_nib};
                w_lead            = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_chars    <= f_idle_chars();
            r_ovf      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_bin      <= bus.bin_in;
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                        r_ovf_pend <= (w_bin_ext >= LP_LIMIT);
                    end
                end
                ST_SHIFT: begin
                    r_bcd <= {w_bcd_adj[BW-2:0], r_bin[BIN_WIDTH-1]};
                    r_bin <= r_bin << 1;
                    r_cnt <= r_cnt + CW'(1);
                end
                ST_FINISH: begin
                    r_chars <= w_chars;
                    r_ovf   <= r_ovf_pend;
                    r_done  <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busy     = (r_state != ST_IDLE);
    assign bus.done     = r_done;
    assign bus.chars    = r_chars;
    assign bus.overflow = r_ovf;

endmodule

// File: tb/tb_bin_to_ascii_digits.sv
// Randomised and directed bench for bin_to_ascii_digits; both blanking variants share one stimulus stream.
module tb_bin_to_ascii_digits;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bin_to_ascii_digits_if #(.BIN_WIDTH(20), .DIGITS(6)) bus_a ();
    bin_to_ascii_digits_if #(.BIN_WIDTH(20), .DIGITS(6)) bus_b ();

    assign bus_b.start  = bus_a.start;
    assign bus_b.bin_in = bus_a.bin_in;

    bin_to_ascii_digits #(.BIN_WIDTH(20), .DIGITS(6), .LZ_BLANK(1'b1)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_a)
    );

    bin_to_ascii_digits #(.BIN_WIDTH(20), .DIGITS(6), .LZ_BLANK(1'b0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_b)
    );

    typedef struct {
        logic [47:0] chars;
        logic        ovf;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_tests  = 0;
    int   n_fail   = 0;
    int   n_acc    = 0;
    int   n_done_a = 0;
    int   n_done_b = 0;

    localparam logic [47:0] RST_A = {8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h30};
    localparam logic [47:0] RST_B = {8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal rendering straight from place values: digit k is blank when the whole value is below 10^k.
    function automatic logic [47:0] ref_chars(input int unsigned v, input bit lz);
        logic [47:0] r;
        longint      lv;
        longint      p;
        r  = '0;
        lv = longint'(v);
        p  = 1;
        for (int k = 0; k < 6; k++) begin
            if (lv >= 1000000)
                r[8*k +: 8] = 8'h2D;
            else if (lz && k > 0 && lv < p)
                r[8*k +: 8] = 8'h20;
            else
                r[8*k +: 8] = 8'h30 + 8'((lv / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic push_exp(input int unsigned v);
        exp_t e;
        e.ovf   = (v >= 32'd1000000);
        e.chars = ref_chars(v, 1'b1);
        q_a.push_back(e);
        e.chars = ref_chars(v, 1'b0);
        q_b.push_back(e);
        n_acc++;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus_a.done === 1'b1) begin
            n_done_a++;
            if (q_a.size() == 0) begin
                check("done_a_unexpected", 64'd1, 64'd0);
            end else begin
                e = q_a.pop_front();
                check("chars_lz1", 64'(bus_a.chars), 64'(e.chars));
                check("ovf_lz1", 64'(bus_a.overflow), 64'(e.ovf));
            end
        end
        if (bus_b.done === 1'b1) begin
            n_done_b++;
            if (q_b.size() == 0) begin
                check("done_b_unexpected", 64'd1, 64'd0);
            end else begin
                e = q_b.pop_front();
                check("chars_lz0", 64'(bus_b.chars), 64'(e.chars));
                check("ovf_lz0", 64'(bus_b.overflow), 64'(e.ovf));
            end
        end
    end

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!bus_a.busy && !bus_a.done) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic convert(input int unsigned v);
        wait_idle();
        bus_a.start  = 1'b1;
        bus_a.bin_in = 20'(v);
        push_exp(v);
        @(negedge clk);
        bus_a.start  = 1'b0;
        bus_a.bin_in = 20'($urandom);
    endtask

    int unsigned directed[11] = '{0, 123456, 1000, 999999, 1000000, 1048575,
                                  1, 9, 10, 100000, 99999};

    initial begin
        int unsigned v;
        int          ph;

        reset        = 1'b1;
        bus_a.start  = 1'b0;
        bus_a.bin_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_chars_lz1", 64'(bus_a.chars), 64'(RST_A));
        check("rst_chars_lz0", 64'(bus_b.chars), 64'(RST_B));
        check("rst_busy", 64'(bus_a.busy), 64'd0);
        check("rst_done", 64'(bus_a.done), 64'd0);
        check("rst_ovf", 64'(bus_a.overflow), 64'd0);

        foreach (directed[i]) convert(directed[i]);

        // start held high with bin_in changing every cycle: accepts only at 0, 23, 46
        wait_idle();
        for (int c = 0; c < 69; c++) begin
            ph = c % 23;
            check("hs_busy", 64'(bus_a.busy), 64'((ph >= 1) && (ph <= 21)));
            check("hs_done", 64'(bus_a.done), 64'(ph == 22));
            v            = $urandom_range(999999, 0);
            bus_a.start  = 1'b1;
            bus_a.bin_in = 20'(v);
            if (ph == 0) push_exp(v);
            @(negedge clk);
        end
        bus_a.start = 1'b0;

        // reset in cycle 10 of a conversion, with a start in the reset cycle that must be dropped
        wait_idle();
        bus_a.start  = 1'b1;
        bus_a.bin_in = 20'd654321;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (9) @(negedge clk);
        reset        = 1'b1;
        bus_a.start  = 1'b1;
        bus_a.bin_in = 20'd777;
        @(negedge clk);
        reset       = 1'b0;
        bus_a.start = 1'b0;
        check("abort_chars_lz1", 64'(bus_a.chars), 64'(RST_A));
        check("abort_chars_lz0", 64'(bus_b.chars), 64'(RST_B));
        check("abort_busy", 64'(bus_a.busy), 64'd0);
        check("abort_ovf", 64'(bus_a.overflow), 64'd0);
        repeat (25) @(negedge clk);
        convert(42);

        for (int unsigned s = 0; s <= 2000; s++) convert(s);
        for (int i = 0; i < 300; i++) begin
            if (i % 5 == 0) convert($urandom_range(1048575, 0));
            else            convert($urandom_range(999999, 0));
        end

        for (int i = 0; i < 60; i++) begin
            if (q_a.size() == 0 && q_b.size() == 0) break;
            @(negedge clk);
        end
        check("drain_a", 64'(q_a.size()), 64'd0);
        check("drain_b", 64'(q_b.size()), 64'd0);
        check("done_count_a", 64'(n_done_a), 64'(n_acc));
        check("done_count_b", 64'(n_done_b), 64'(n_acc));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
